// File: rtl/seven_seg_pkg.sv
// Shared segment glyphs and the segment-vector type for the seven-segment decoder.
// Every pattern here is active-high with bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t DIGIT_0 = 7'b0111111;
    localparam seg_t DIGIT_1 = 7'b0000110;
    localparam seg_t DIGIT_2 = 7'b1011011;
    localparam seg_t DIGIT_3 = 7'b1001111;
    localparam seg_t DIGIT_4 = 7'b1100110;
    localparam seg_t DIGIT_5 = 7'b1101101;
    localparam seg_t DIGIT_6 = 7'b1111101;
    localparam seg_t DIGIT_7 = 7'b0000111;
    localparam seg_t DIGIT_8 = 7'b1111111;
    localparam seg_t DIGIT_9 = 7'b1101111;

    localparam seg_t HEX_A = 7'b1110111;
    localparam seg_t HEX_B = 7'b1111100;
    localparam seg_t HEX_C = 7'b0111001;
    localparam seg_t HEX_D = 7'b1011110;
    localparam seg_t HEX_E = 7'b1111001;
    localparam seg_t HEX_F = 7'b1110001;

    localparam seg_t SEG_ALL_ON  = 7'b1111111;
    localparam seg_t SEG_ALL_OFF = 7'b0000000;

endpackage

// File: rtl/seven_seg_lut.sv
// Combinational glyph lookup: 4-bit code to active-high segment pattern.
// Codes 10-15 show A-F only when hex_en_i is set, otherwise they are blank.
module seven_seg_lut
    import seven_seg_pkg::*;
(
    input  logic [3:0] num_i,
    input  logic       hex_en_i,
    output seg_t       pattern_o
);

    always_comb begin
        pattern_o = SEG_ALL_OFF;
        case (num_i)
            4'd0:  pattern_o = DIGIT_0;
            4'd1:  pattern_o = DIGIT_1;
            4'd2:  pattern_o = DIGIT_2;
            4'd3:  pattern_o = DIGIT_3;
            4'd4:  pattern_o = DIGIT_4;
            4'd5:  pattern_o = DIGIT_5;
            4'd6:  pattern_o = DIGIT_6;
            4'd7:  pattern_o = DIGIT_7;
            4'd8:  pattern_o = DIGIT_8;
            4'd9:  pattern_o = DIGIT_9;
            4'd10: if (hex_en_i) pattern_o = HEX_A;
            4'd11: if (hex_en_i) pattern_o = HEX_B;
            4'd12: if (hex_en_i) pattern_o = HEX_C;
            4'd13: if (hex_en_i) pattern_o = HEX_D;
            4'd14: if (hex_en_i) pattern_o = HEX_E;
            4'd15: if (hex_en_i) pattern_o = HEX_F;
            default: pattern_o = SEG_ALL_OFF;
        endcase
    end

endmodule

// File: rtl/seven_segment_decoder.sv
// Seven-segment decoder top: lamp-test/blank priority, output polarity,
// a registered copy of the segment drive and a sticky invalid-code flag.
module seven_segment_decoder
    import seven_seg_pkg::*;
#(
    parameter bit HEX_EN     = 1'b0,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num,
    input  logic       lt,
    input  logic       bi,
    output seg_t       seg,
    output seg_t       seg_q,
    output logic       err
);

    localparam seg_t OFF_PATTERN = ACTIVE_LOW ? ~SEG_ALL_OFF : SEG_ALL_OFF;

    seg_t lutPattern;
    seg_t prioPattern;
    seg_t seg_d;
    logic errCond;
    logic err_d;
    logic err_q;

    seven_seg_lut uLut (
        .num_i     (num),
        .hex_en_i  (HEX_EN),
        .pattern_o (lutPattern)
    );

    always_comb begin
        prioPattern = lutPattern;
        if (lt) begin
            prioPattern = SEG_ALL_ON;
        end else if (bi) begin
            prioPattern = SEG_ALL_OFF;
        end
    end

    // Polarity is applied last so lamp test and blanking invert along with the digits.
    assign seg     = ACTIVE_LOW ? ~prioPattern : prioPattern;
    assign seg_d   = seg;
    assign errCond = !HEX_EN && (num > 4'd9) && !lt && !bi;
    assign err_d   = err_q | errCond;
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= OFF_PATTERN;
            err_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Self-checking bench for seven_segment_decoder: three parameterisations driven
// from shared inputs and compared against a table-driven reference model.
module tb_seven_segment_decoder;

    localparam int NDUT = 3;
    localparam logic [6:0] GLYPHS [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };
    localparam bit HEX_CFG [NDUT] = '{1'b0, 1'b1, 1'b0};
    localparam bit LOW_CFG [NDUT] = '{1'b0, 1'b0, 1'b1};

    logic       clk;
    logic       rst;
    logic [3:0] num;
    logic       lt;
    logic       bi;
    logic [6:0] segOut  [NDUT];
    logic [6:0] segQOut [NDUT];
    logic       errOut  [NDUT];

    logic [6:0] expSegQ [NDUT];
    logic       expErr  [NDUT];
    int         checks;
    int         errors;

    seven_segment_decoder #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b0)) uDef (
        .clk(clk), .rst(rst), .num(num), .lt(lt), .bi(bi),
        .seg(segOut[0]), .seg_q(segQOut[0]), .err(errOut[0])
    );
    seven_segment_decoder #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b0)) uHex (
        .clk(clk), .rst(rst), .num(num), .lt(lt), .bi(bi),
        .seg(segOut[1]), .seg_q(segQOut[1]), .err(errOut[1])
    );
    seven_segment_decoder #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b1)) uLow (
        .clk(clk), .rst(rst), .num(num), .lt(lt), .bi(bi),
        .seg(segOut[2]), .seg_q(segQOut[2]), .err(errOut[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pattern straight from the glyph table and the priority rules.
    function automatic logic [6:0] refSeg(input int n, input bit hexEn, input bit actLow,
                                          input bit ltV, input bit biV);
        logic [6:0] p;
        if (ltV)                   p = 7'h7f;
        else if (biV)              p = 7'h00;
        else if (n > 9 && !hexEn)  p = 7'h00;
        else                       p = GLYPHS[n];
        return actLow ? ~p : p;
    endfunction

    task automatic setInputs(input logic r, input logic [3:0] n, input logic l, input logic b);
        @(negedge clk);
        rst = r;
        num = n;
        lt  = l;
        bi  = b;
        #1;
    endtask

    // Advance one rising edge and update the registered-output model from the sampled inputs.
    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                expSegQ[d] = LOW_CFG[d] ? 7'h7f : 7'h00;
                expErr[d]  = 1'b0;
            end else begin
                expSegQ[d] = refSeg(int'(num), HEX_CFG[d], LOW_CFG[d], lt, bi);
                expErr[d]  = expErr[d] | (!HEX_CFG[d] && num > 4'd9 && !lt && !bi);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        setInputs(1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (segQOut[d] !== expSegQ[d]) begin
                errors++;
                $display("[TB] FAIL reset_seg_q dut%0d: got %b expected %b", d, segQOut[d], expSegQ[d]);
            end
            checks++;
            if (errOut[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_err dut%0d: got %b expected 0", d, errOut[d]);
            end
            checks++;
            if (segOut[d] !== refSeg(0, HEX_CFG[d], LOW_CFG[d], 1'b0, 1'b0)) begin
                errors++;
                $display("[TB] FAIL reset_seg_comb dut%0d: got %b expected %b", d, segOut[d],
                         refSeg(0, HEX_CFG[d], LOW_CFG[d], 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_decimal_sweep();
        for (int n = 0; n < 10; n++) begin
            setInputs(1'b0, 4'(n), 1'b0, 1'b0);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (segOut[d] !== refSeg(n, HEX_CFG[d], LOW_CFG[d], 1'b0, 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL decimal num=%0d dut%0d: got %b expected %b", n, d, segOut[d],
                             refSeg(n, HEX_CFG[d], LOW_CFG[d], 1'b0, 1'b0));
                end
            end
        end
    endtask

    task automatic test_hex_disabled_err();
        setInputs(1'b0, 4'd12, 1'b0, 1'b0);
        checks++;
        if (segOut[0] !== 7'b0000000) begin
            errors++;
            $display("[TB] FAIL blank_code12: got %b expected 0000000", segOut[0]);
        end
        tick();
        checks++;
        if (errOut[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_set: got %b expected 1", errOut[0]);
        end
        setInputs(1'b0, 4'd3, 1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if (errOut[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky: got %b expected 1", errOut[0]);
        end
        setInputs(1'b1, 4'd3, 1'b0, 1'b0);
        tick();
        checks++;
        if (errOut[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_clear: got %b expected 0", errOut[0]);
        end
        // Reset wins over a simultaneous error condition.
        setInputs(1'b1, 4'd14, 1'b0, 1'b0);
        tick();
        checks++;
        if (errOut[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_reset_wins: got %b expected 0", errOut[0]);
        end
    endtask

    task automatic test_hex_enabled();
        for (int n = 10; n < 16; n++) begin
            setInputs(1'b0, 4'(n), 1'b0, 1'b0);
            checks++;
            if (segOut[1] !== GLYPHS[n]) begin
                errors++;
                $display("[TB] FAIL hex num=%0d: got %b expected %b", n, segOut[1], GLYPHS[n]);
            end
            tick();
            checks++;
            if (errOut[1] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hex_err num=%0d: got %b expected 0", n, errOut[1]);
            end
        end
    endtask

    task automatic test_priority();
        logic [6:0] want [3];
        want = '{7'b1111111, 7'b0000000, 7'b1101101};
        for (int s = 0; s < 3; s++) begin
            setInputs(1'b0, 4'd5, (s == 0), (s < 2));
            checks++;
            if (segOut[0] !== want[s]) begin
                errors++;
                $display("[TB] FAIL priority step%0d: got %b expected %b", s, segOut[0], want[s]);
            end
            checks++;
            if (segOut[2] !== ~want[s]) begin
                errors++;
                $display("[TB] FAIL priority_low step%0d: got %b expected %b", s, segOut[2], ~want[s]);
            end
        end
    endtask

    task automatic test_active_low();
        setInputs(1'b0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (segOut[2] !== 7'b1000000) begin
            errors++;
            $display("[TB] FAIL active_low_zero: got %b expected 1000000", segOut[2]);
        end
        setInputs(1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (segQOut[2] !== 7'b1111111) begin
            errors++;
            $display("[TB] FAIL active_low_reset: got %b expected 1111111", segQOut[2]);
        end
    endtask

    task automatic test_registered();
        setInputs(1'b0, 4'd4, 1'b0, 1'b0);
        tick();
        setInputs(1'b0, 4'd7, 1'b0, 1'b0);
        checks++;
        if (segQOut[0] !== 7'b1100110) begin
            errors++;
            $display("[TB] FAIL reg_edge_k: got %b expected 1100110", segQOut[0]);
        end
        tick();
        checks++;
        if (segQOut[0] !== 7'b0000111) begin
            errors++;
            $display("[TB] FAIL reg_edge_k1: got %b expected 0000111", segQOut[0]);
        end
        // Mid-cycle wiggles must not reach the registers.
        #2 num = 4'd13;
        #1 lt = 1'b1;
        #1 begin num = 4'd7; lt = 1'b0; end
        checks++;
        if (segQOut[0] !== 7'b0000111 || errOut[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reg_glitch: got %b/%b expected 0000111/0", segQOut[0], errOut[0]);
        end
        setInputs(1'b0, 4'd9, 1'b0, 1'b0);
        tick();
        setInputs(1'b1, 4'd9, 1'b0, 1'b0);
        tick();
        checks++;
        if (segQOut[0] !== 7'b0000000 || segOut[0] !== 7'b1101111) begin
            errors++;
            $display("[TB] FAIL reg_reset: got %b/%b expected 0000000/1101111", segQOut[0], segOut[0]);
        end
        setInputs(1'b0, 4'd9, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic       r;
        logic [3:0] n;
        logic       l;
        logic       b;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 15) == 0);
            n = 4'($urandom_range(0, 15));
            l = ($urandom_range(0, 7) == 0);
            b = ($urandom_range(0, 5) == 0);
            setInputs(r, n, l, b);
            tick();
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (segOut[d] !== refSeg(int'(n), HEX_CFG[d], LOW_CFG[d], l, b)) begin
                    errors++;
                    $display("[TB] FAIL rand_seg it%0d dut%0d: got %b expected %b", i, d, segOut[d],
                             refSeg(int'(n), HEX_CFG[d], LOW_CFG[d], l, b));
                end
                checks++;
                if (segQOut[d] !== expSegQ[d]) begin
                    errors++;
                    $display("[TB] FAIL rand_seg_q it%0d dut%0d: got %b expected %b", i, d, segQOut[d], expSegQ[d]);
                end
                checks++;
                if (errOut[d] !== expErr[d]) begin
                    errors++;
                    $display("[TB] FAIL rand_err it%0d dut%0d: got %b expected %b", i, d, errOut[d], expErr[d]);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        num = 4'd0;
        lt  = 1'b0;
        bi  = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            expSegQ[d] = 7'h00;
            expErr[d]  = 1'b0;
        end
        test_reset();
        test_decimal_sweep();
        test_hex_disabled_err();
        test_hex_enabled();
        test_priority();
        test_active_low();
        test_registered();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_decoder.md
SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

Interface
REQ-001 Parameter HEX_EN, default 0: 1 = codes 10-15 display hex glyphs A-F; 0 = codes 10-15 blank.
REQ-002 Parameter ACTIVE_LOW, default 0: 1 = every segment output inverted (segment on = 0).
REQ-003 The design SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all registered outputs.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 num  input  4  BCD/hex digit to display.
REQ-007 lt   input  1  lamp test; forces all seven segments on.
REQ-008 bi   input  1  blanking; forces all segments off; lower priority than lt.
REQ-009 seg    output  7  combinational segment drive, bit order {g,f,e,d,c,b,a} (seg[0]=a, seg[6]=g).
REQ-010 seg_q  output  7  seg registered on clk.
REQ-011 err    output  1  sticky flag: a code >9 was sampled while HEX_EN=0.

Function
REQ-012 seg SHALL be purely combinational from num/lt/bi, with zero clock latency, settling within one time step of an input change.
REQ-013 Active-high digit map (ACTIVE_LOW=0):
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
- 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
REQ-014 With HEX_EN=1, map codes 10-15:
- A=1110111, b=1111100, C=0111001
- d=1011110, E=1111001, F=1110001
REQ-015 With HEX_EN=0, codes 10-15 SHALL drive all segments off.
REQ-016 Priority: lt (all on, 1111111), then bi (all off), then the num decode.
REQ-017 With ACTIVE_LOW=1, the final pattern SHALL be bitwise inverted after priority resolution; "off" then means 1111111.
REQ-018 seg_q SHALL equal the seg value sampled at the previous rising clk edge (1-cycle latency).
REQ-019 err SHALL set at a rising edge when HEX_EN=0, num>9, lt=0 and bi=0.
REQ-020 err SHALL then hold at 1 until rst; a simultaneous rst and error condition SHALL leave err=0 (reset wins).
REQ-021 Input changes between clock edges SHALL affect only seg, not seg_q or err.

Reset
REQ-022 At a rising clk edge with rst=1: seg_q = all-off pattern (0000000, or 1111111 when ACTIVE_LOW=1) and err=0.
REQ-023 rst SHALL NOT affect the combinational seg output.
REQ-024 Asserting rst mid-operation SHALL take effect at the next edge only; no asynchronous path.

Structure
REQ-025 Package seven_seg_pkg SHALL hold:
- the 16-entry glyph constants (DIGIT_0..DIGIT_9, HEX_A..HEX_F)
- SEG_ALL_ON and SEG_ALL_OFF
- the segment-vector typedef (7 bits, {g..a}).
REQ-026 One combinational sub-module, seven_seg_lut (num, hex_en -> active-high pattern), SHALL be instantiated.
REQ-027 The top level SHALL add priority, polarity, registers and the err logic; no other sub-modules.

Verification
REQ-028 Defaults, lt=bi=0: num swept 0..9, check seg one step after each change -> seg matches REQ-013 (e.g. num=2 -> 1011011, num=8 -> 1111111).
REQ-029 HEX_EN=0, num=12 -> seg=0000000; next edge -> err=1; num=3 afterwards -> err stays 1 until rst pulse, then 0.
REQ-030 HEX_EN=1, num=10..15 -> A..F patterns of REQ-014; err stays 0.
REQ-031 num=5 with lt=1, bi=1 -> seg=1111111; then lt=0 -> seg=0000000; then bi=0 -> seg=1101101.
REQ-032 ACTIVE_LOW=1: num=0 -> seg=1000000; rst at an edge -> seg_q=1111111.
REQ-033 Registered path: num=4 before edge k, num=7 after edge k -> seg_q=1100110 after edge k and 0000111 after edge k+1; rst during a steady num=9 -> seg_q=0000000 next edge while seg=1101111.
